// File: rtl/sync_cnt_pkg.sv
// rtl/sync_cnt_pkg.sv - shared counter types and limits for the up/down counter family
package sync_cnt_pkg;

    localparam int CNT_MAX_WIDTH = 16;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_mode_e;

endpackage

// File: rtl/t_ff.sv
// rtl/t_ff.sv - toggle flip-flop cell with asynchronous active-low reset
module t_ff (
    input  logic clk,
    input  logic T,
    input  logic reset_n,
    output logic Q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q <= 1'b0;
        end else if (T) begin
            Q <= ~Q;
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - T flip-flop down counter with load, cascadable tc and sticky underflow
// Optional macro SYNC_DOWN_CNT_AUTORELOAD_EN: decrement from zero reloads the last load_val.
module sync_down_counter
    import sync_cnt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             underflow
);

    localparam cnt_mode_e MODE = CNT_DOWN;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] t_chain;
    logic [WIDTH-1:0] t_d;
    logic             wrap;
    logic             underflow_q;
    logic             underflow_d;

    assign zero = (q_q == '0);
    assign tc   = en & zero;
    assign wrap = en & zero & ~load;

    // Borrow chain: a bit toggles only when every lower bit is already zero.
    always_comb begin
        logic run;
        run     = en;
        t_chain = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_chain[i] = run;
            run        = run & ((MODE == CNT_DOWN) ? ~q_q[i] : q_q[i]);
        end
    end

`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_val;
        end
    end

    // On a wrap q is zero, so toggling with the reload value lands exactly on it.
    always_comb begin
        if (load) begin
            t_d = q_q ^ load_val;
        end else if (wrap) begin
            t_d = q_q ^ reload_q;
        end else begin
            t_d = t_chain;
        end
    end
`else
    always_comb begin
        if (load) begin
            t_d = q_q ^ load_val;
        end else begin
            t_d = t_chain;
        end
    end
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        t_ff u_t_ff (
            .clk     (clk),
            .T       (t_d[g]),
            .reset_n (reset_n),
            .Q       (q_q[g])
        );
    end

    // Set beats clear when both land on the same edge.
    always_comb begin
        underflow_d = underflow_q;
        if (wrap) begin
            underflow_d = 1'b1;
        end else if (clr_flag) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign q         = q_q;
    assign underflow = underflow_q;

endmodule
